mmio_bus_arbiter: RTL and testbench

Two-master arbiter that shares the single FPro MMIO bus in front of the MMIO controller between the processor (master 0) and an auxiliary master (master 1, e.g. a UART debug/loader engine). Each master uses a request/acknowledge handshake. The arbiter serialises their accesses into single-cycle FPro bus transactions, registers the read data, and returns it with the acknowledge. Grant is round-robin, with an optional lock that lets a master keep the bus for read-modify-write sequences.

---
 rtl/mmio_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_mmio_bus_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mmio_bus_arbiter: round-robin two-master arbiter with lock for the FPro MMIO bus
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mmio_bus_arbiter #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_wr_i,
  input  logic              m0_lock_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wr_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rd_data_o,
  output logic              m0_gnt_o,
  input  logic              m1_req_i,
  input  logic              m1_wr_i,
  input  logic              m1_lock_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wr_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rd_data_o,
  output logic              m1_gnt_o,
  output logic              mmio_cs_o,
  output logic              mmio_wr_o,
  output logic              mmio_rd_o,
  output logic [ADDR_W-1:0] mmio_addr_o,
  output logic [DATA_W-1:0] mmio_wr_data_o,
  input  logic [DATA_W-1:0] mmio_rd_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_gnt_q, last_gnt_d;
  logic              lock_hold_q, lock_hold_d;
  logic              lock_owner_q, lock_owner_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;

  logic w_owner_req;
  logic w_sel_wr;
  logic w_sel_lock;
  logic w_winner;

  always_comb begin
    w_owner_req = lock_owner_q ? m1_req_i : m0_req_i;
    w_sel_wr    = sel_q ? m1_wr_i : m0_wr_i;
    w_sel_lock  = sel_q ? m1_lock_i : m0_lock_i;
    // Lock beats round-robin; on a tie the master not served last wins.
    if (lock_hold_q && w_owner_req) begin
      w_winner = lock_owner_q;
    end else if (m0_req_i && m1_req_i) begin
      w_winner = ~last_gnt_q;
    end else begin
      w_winner = m1_req_i;
    end
  end

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    last_gnt_d     = last_gnt_q;
    lock_hold_d    = lock_hold_q;
    lock_owner_d   = lock_owner_q;
    rd_buf_d       = rd_buf_q;
    m0_ack_o       = 1'b0;
    m1_ack_o       = 1'b0;
    m0_gnt_o       = 1'b0;
    m1_gnt_o       = 1'b0;
    mmio_cs_o      = 1'b0;
    mmio_wr_o      = 1'b0;
    mmio_rd_o      = 1'b0;
    mmio_addr_o    = '0;
    mmio_wr_data_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (lock_hold_q && !w_owner_req) begin
          lock_hold_d = 1'b0;
        end
        if (m0_req_i || m1_req_i) begin
          sel_d   = w_winner;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m0_gnt_o       = ~sel_q;
        m1_gnt_o       = sel_q;
        mmio_cs_o      = 1'b1;
        mmio_wr_o      = w_sel_wr;
        mmio_rd_o      = ~w_sel_wr;
        mmio_addr_o    = sel_q ? m1_addr_i : m0_addr_i;
        mmio_wr_data_o = sel_q ? m1_wr_data_i : m0_wr_data_i;
        if (!w_sel_wr) begin
          rd_buf_d = mmio_rd_data_i;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        m0_gnt_o     = ~sel_q;
        m1_gnt_o     = sel_q;
        m0_ack_o     = ~sel_q;
        m1_ack_o     = sel_q;
        last_gnt_d   = sel_q;
        lock_hold_d  = w_sel_lock;
        lock_owner_d = sel_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      last_gnt_q   <= 1'b1;
      lock_hold_q  <= 1'b0;
      lock_owner_q <= 1'b0;
      rd_buf_q     <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_gnt_q   <= last_gnt_d;
      lock_hold_q  <= lock_hold_d;
      lock_owner_q <= lock_owner_d;
      rd_buf_q     <= rd_buf_d;
    end
  end

  assign m0_rd_data_o = rd_buf_q;
  assign m1_rd_data_o = rd_buf_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mmio_bus_arbiter: scoreboard bench for the two-master MMIO bus arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mmio_bus_arbiter;
  localparam int AW = 21;
  localparam int DW = 32;
  localparam logic [DW-1:0] C_JUNK = 32'h0BAD_F00D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wr_data, m1_wr_data;
  logic          m0_ack, m1_ack, m0_gnt, m1_gnt;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          mmio_cs, mmio_wr, mmio_rd;
  logic [AW-1:0] mmio_addr;
  logic [DW-1:0] mmio_wr_data;
  logic [DW-1:0] slot = '0;

  always #5 clk = ~clk;

  mmio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_wr_i(m0_wr), .m0_lock_i(m0_lock),
    .m0_addr_i(m0_addr), .m0_wr_data_i(m0_wr_data),
    .m0_ack_o(m0_ack), .m0_rd_data_o(m0_rd_data), .m0_gnt_o(m0_gnt),
    .m1_req_i(m1_req), .m1_wr_i(m1_wr), .m1_lock_i(m1_lock),
    .m1_addr_i(m1_addr), .m1_wr_data_i(m1_wr_data),
    .m1_ack_o(m1_ack), .m1_rd_data_o(m1_rd_data), .m1_gnt_o(m1_gnt),
    .mmio_cs_o(mmio_cs), .mmio_wr_o(mmio_wr), .mmio_rd_o(mmio_rd),
    .mmio_addr_o(mmio_addr), .mmio_wr_data_o(mmio_wr_data),
    .mmio_rd_data_i(slot)
  );

  typedef struct packed {
    logic          m;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] slot;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          bus_q[$];
  exp_t          ack_q[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            last_cs_cyc = -100;
  int            last_ack_cyc[2];
  logic [DW-1:0] model_rdbuf = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected bus access and ack, in service order; writes return the held read buffer.
  function automatic void expect_txn(input logic m, input logic wr, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d, input logic [DW-1:0] s);
    exp_t e;
    e.m = m; e.wr = wr; e.addr = a; e.wdata = d; e.slot = s;
    e.rdata = wr ? model_rdbuf : s;
    if (!wr) model_rdbuf = s;
    bus_q.push_back(e);
    ack_q.push_back(e);
  endfunction

  // Monitor: compares every bus strobe and every ack against the queues.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mmio_cs) begin
          chk("cs_spacing", 64'(cyc - last_cs_cyc >= 3), 1);
          last_cs_cyc = cyc;
          if (bus_q.size() == 0) begin
            chk("unexpected_cs", 1, 0);
          end else begin
            e = bus_q.pop_front();
            slot = e.slot;
            chk("issue_gnt", {m0_gnt, m1_gnt}, e.m ? 2'b01 : 2'b10);
            chk("issue_wr_rd", {mmio_wr, mmio_rd}, {e.wr, ~e.wr});
            chk("issue_addr", mmio_addr, e.addr);
            chk("issue_wdata", mmio_wr_data, e.wdata);
          end
        end else begin
          chk("idle_bus", {mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}, 0);
        end
        if (m0_ack || m1_ack) begin
          if (m0_ack && m1_ack) begin
            chk("dual_ack", 1, 0);
          end else if (ack_q.size() == 0) begin
            chk("unexpected_ack", 1, 0);
          end else begin
            e = ack_q.pop_front();
            last_ack_cyc[m1_ack ? 1 : 0] = cyc;
            chk("ack_master", m1_ack, e.m);
            chk("ack_gnt", {m0_gnt, m1_gnt}, e.m ? 2'b01 : 2'b10);
            chk("ack_rdata", e.m ? m1_rd_data : m0_rd_data, e.rdata);
          end
        end else if (!mmio_cs) begin
          chk("idle_gnt", {m0_gnt, m1_gnt}, 0);
        end
      end
    end
  end

  // Present one transaction and hold it through its ack; returns at the start of the next IDLE.
  task automatic drive(input logic m, input logic wr, input logic lock,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    if (m) begin
      m1_wr = wr; m1_lock = lock; m1_addr = a; m1_wr_data = d; m1_req = 1'b1;
    end else begin
      m0_wr = wr; m0_lock = lock; m0_addr = a; m0_wr_data = d; m0_req = 1'b1;
    end
    @(negedge clk);
    while (!(m ? m1_ack : m0_ack) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", m ? m1_ack : m0_ack, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
    bus_q.delete(); ack_q.delete();
    model_rdbuf = '0;
    last_cs_cyc = -100;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    m0_req = 0; m0_wr = 0; m0_lock = 0; m0_addr = '0; m0_wr_data = '0;
    m1_req = 0; m1_wr = 0; m1_lock = 0; m1_addr = '0; m1_wr_data = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ack", {m0_ack, m1_ack}, 0);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
    chk("rst_cs", mmio_cs, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read with exact latency
    expect_txn(1'b0, 1'b0, 21'h000C0, '0, 32'hDEADBEEF);
    m0_wr = 1'b0; m0_addr = 21'h000C0; m0_req = 1'b1;
    @(negedge clk);
    chk("rd_cs_before", mmio_cs, 0);
    @(negedge clk);
    chk("rd_issue", {mmio_cs, mmio_rd, mmio_wr}, 3'b110);
    chk("rd_no_ack_in_issue", {m0_ack, m1_ack}, 0);
    @(negedge clk);
    chk("rd_cs_after", mmio_cs, 0);
    chk("rd_ack", {m0_ack, m1_ack}, 2'b10);
    chk("rd_data", m0_rd_data, 32'hDEADBEEF);
    @(posedge clk);
    #1 m0_req = 1'b0;

    // Single write; read buffer must survive it
    expect_txn(1'b1, 1'b1, 21'h00088, 32'h0000A5A5, C_JUNK);
    drive(1'b1, 1'b1, 1'b0, 21'h00088, 32'h0000A5A5);
    m1_req = 1'b0;
    chk("wr_rdbuf_kept", m1_rd_data, 32'hDEADBEEF);

    // Reset in the middle of an ISSUE cycle
    expect_txn(1'b0, 1'b0, 21'h00010, '0, 32'h11112222);
    m0_wr = 1'b0; m0_addr = 21'h00010; m0_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!mmio_cs && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_cs_seen", mmio_cs, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", mmio_cs, 0);
    chk("mid_rst_gnt", {m0_gnt, m1_gnt}, 0);
    chk("mid_rst_ack", {m0_ack, m1_ack}, 0);
    chk("mid_rst_rdbuf", m0_rd_data, 0);
    bus_q.delete(); ack_q.delete();
    model_rdbuf = '0;
    last_cs_cyc = -100;
    @(posedge clk);
    #1;
    chk("mid_rst_hold_cs", mmio_cs, 0);
    rst_n = 1'b1;
    expect_txn(1'b0, 1'b0, 21'h00010, '0, 32'h11112222);
    @(negedge clk);
    chk("post_rst_cs_before", mmio_cs, 0);
    @(negedge clk);
    chk("post_rst_issue", mmio_cs, 1);
    @(negedge clk);
    chk("post_rst_ack", m0_ack, 1);
    @(posedge clk);
    #1 m0_req = 1'b0;

    // Contention: alternate service, M0 first after reset
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      expect_txn(1'b0, 1'b0, AW'(21'h100 + i), '0, DW'(32'hA000_0000 + i));
      expect_txn(1'b1, 1'b1, AW'(21'h200 + i), DW'(32'hB000_0000 + i), C_JUNK);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, AW'(21'h100 + i), '0);
        m0_req = 1'b0;
      end
      begin
        for (int j = 0; j < 4; j++) drive(1'b1, 1'b1, 1'b0, AW'(21'h200 + j), DW'(32'hB000_0000 + j));
        m1_req = 1'b0;
      end
    join
    repeat (2) @(posedge clk);
    #1 chk("contention_drained", 64'(bus_q.size() + ack_q.size()), 0);

    // Lock: m1 keeps the bus for three accesses while m0 waits
    expect_txn(1'b1, 1'b0, 21'h00300, '0, 32'h0000_00C1);
    expect_txn(1'b1, 1'b0, 21'h00304, '0, 32'h0000_00C2);
    expect_txn(1'b1, 1'b1, 21'h00308, 32'hC0C0_C0C0, C_JUNK);
    expect_txn(1'b0, 1'b0, 21'h00400, '0, 32'h0000_00D0);
    fork
      begin
        drive(1'b1, 1'b0, 1'b1, 21'h00300, '0);
        drive(1'b1, 1'b0, 1'b1, 21'h00304, '0);
        drive(1'b1, 1'b1, 1'b0, 21'h00308, 32'hC0C0_C0C0);
        m1_req = 1'b0;
      end
      begin
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 21'h00400, '0);
        m0_req = 1'b0;
      end
    join
    chk("lock_m0_after_unlock", 64'(last_cs_cyc - last_ack_cyc[1]), 2);

    // Lock owner drops req: m1 gets the next IDLE slot
    expect_txn(1'b0, 1'b1, 21'h00500, 32'h0000_0055, C_JUNK);
    expect_txn(1'b1, 1'b0, 21'h00600, '0, 32'h0000_00E6);
    fork
      begin
        drive(1'b0, 1'b1, 1'b1, 21'h00500, 32'h0000_0055);
        m0_req = 1'b0;
        m0_lock = 1'b0;
      end
      begin
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 21'h00600, '0);
        m1_req = 1'b0;
      end
    join
    chk("lockdrop_m1_next", 64'(last_cs_cyc - last_ack_cyc[0]), 2);

    repeat (3) @(posedge clk);
    #1 chk("queues_empty", 64'(bus_q.size() + ack_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
